prog_ctr_seq: RTL and testbench

Parametrised program-sequencing unit replacing the single-program PC: holds the fetch address, selects among several program entry points, and supports conditional/unconditional absolute and PC-relative jumps plus call/return through a small hardware return stack. Sits between the decoder/ALU flags and instruction memory; its registered `ProgCtr` drives the instruction ROM address.

---
 rtl/prog_ctr_pkg.sv | 26 ++
 rtl/ret_stack.sv | 63 ++++++
 rtl/prog_ctr_seq.sv | 154 +++++++++++++++
 tb/tb_prog_ctr_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/prog_ctr_pkg.sv
// Shared types for the program-sequencing unit: branch opcodes and FSM states.
// Imported by prog_ctr_seq and ret_stack.
package prog_ctr_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    JE   = 3'd1,
    JNE  = 3'd2,
    JMP  = 3'd3,
    REL  = 3'd4,
    CALL = 3'd5,
    RET  = 3'd6
  } br_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_e;

  // Pointer width that can also represent the "full" count DEPTH.
  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// DEPTH x L hardware return stack (LIFO). Only the stack pointer is reset;
// entry storage is plain registers whose contents are don't-care after reset.
module ret_stack
  import prog_ctr_pkg::*;
#(
  parameter int L     = 10,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clr,
  input  logic         Push,
  input  logic         Pop,
  input  logic [L-1:0] PushData,
  output logic [L-1:0] TopData,
  output logic         Full,
  output logic         Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = sp_width(DEPTH);
  localparam logic [PW-1:0] IDX_ONE = PW'(1);

  logic [L-1:0]  mem_q [DEPTH];
  logic [SW-1:0] sp_q;
  logic [SW-1:0] sp_d;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] top_idx;

  assign wr_idx  = sp_q[PW-1:0];
  // At sp == DEPTH the low bits wrap to 0, so top_idx lands on DEPTH-1.
  assign top_idx = sp_q[PW-1:0] - IDX_ONE;

  assign Full    = (sp_q == SW'(DEPTH));
  assign Empty   = (sp_q == '0);
  assign TopData = mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (Clr) begin
      sp_d = '0;
    end else if (Push && !Full) begin
      sp_d = sp_q + SW'(1);
    end else if (Pop && !Empty) begin
      sp_d = sp_q - SW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clr && Push && !Full) begin
      mem_q[wr_idx] <= PushData;
    end
  end

endmodule

// File: rtl/prog_ctr_seq.sv
// Program sequencer: fetch-address register with program entry select,
// absolute/relative/conditional jumps and call/return via ret_stack.
//
//   state | meaning
//   IDLE  | out of reset, waiting for Start with a valid ProgSel
//   RUN   | fetching; ProgCtr advances per BrOp unless stalled or halted
//   DONE  | program ended (Halt or stack fault); waiting for next Start
module prog_ctr_seq
  import prog_ctr_pkg::*;
#(
  parameter int                           L          = 10,
  parameter int                           NPROG      = 3,
  parameter logic [NPROG-1:0][L-1:0]      START_ADDR = {10'h200, 10'h100, 10'h000},
  parameter int                           DEPTH      = 4,
  parameter int                           OW         = 6,
  localparam int                          SELW       = (NPROG > 1) ? $clog2(NPROG) : 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [SELW-1:0] ProgSel,
  input  logic            Stall,
  input  logic            Halt,
  input  logic [2:0]      BrOp,
  input  logic            Zero,
  input  logic [L-1:0]    DestAddr,
  input  logic [OW-1:0]   Offset,
  output logic [L-1:0]    ProgCtr,
  output logic            Busy,
  output logic            Done,
  output logic            Fault
);

  pc_state_e    state_q, state_d;
  logic [L-1:0] pc_q, pc_d;
  logic         fault_q, fault_d;

  logic         stk_clr, stk_push, stk_pop;
  logic [L-1:0] stk_top;
  logic         stk_full, stk_empty;

  logic [L-1:0] pc_inc;
  logic [L-1:0] pc_rel;
  logic [L-1:0] start_pc;
  logic         sel_ok;
  br_op_e       op;

  assign pc_inc = pc_q + L'(1);
  assign pc_rel = pc_q + {{(L-OW){Offset[OW-1]}}, Offset};
  assign op     = br_op_e'(BrOp);

  // Entry-address mux; out-of-range ProgSel leaves sel_ok low so Start is ignored.
  always_comb begin
    start_pc = '0;
    sel_ok   = 1'b0;
    for (int i = 0; i < NPROG; i++) begin
      if (ProgSel == SELW'(i)) begin
        start_pc = START_ADDR[i];
        sel_ok   = 1'b1;
      end
    end
  end

  ret_stack #(
    .L     (L),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .Clk      (Clk),
    .Reset    (Reset),
    .Clr      (stk_clr),
    .Push     (stk_push),
    .Pop      (stk_pop),
    .PushData (pc_inc),
    .TopData  (stk_top),
    .Full     (stk_full),
    .Empty    (stk_empty)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fault_d  = fault_q;
    stk_clr  = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (Start && sel_ok) begin
          pc_d    = start_pc;
          fault_d = 1'b0;
          stk_clr = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (Stall) begin
          state_d = RUN;
        end else if (Halt) begin
          state_d = DONE;
        end else begin
          case (op)
            JE:      pc_d = Zero ? DestAddr : pc_inc;
            JNE:     pc_d = Zero ? pc_inc : DestAddr;
            JMP:     pc_d = DestAddr;
            REL:     pc_d = pc_rel;
            CALL: begin
              if (stk_full) begin
                fault_d = 1'b1;
                state_d = DONE;
              end else begin
                stk_push = 1'b1;
                pc_d     = DestAddr;
              end
            end
            RET: begin
              if (stk_empty) begin
                fault_d = 1'b1;
                state_d = DONE;
              end else begin
                stk_pop = 1'b1;
                pc_d    = stk_top;
              end
            end
            default: pc_d = pc_inc;
          endcase
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_comb begin
    ProgCtr = pc_q;
    Fault   = fault_q;
    Busy    = (state_q == RUN);
    Done    = (state_q == DONE);
  end

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Self-checking bench for prog_ctr_seq: vector table through a scoreboard queue,
// plus hand sequences for reset and async reset mid-run.
module tb_prog_ctr_seq;
  import prog_ctr_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [1:0] ProgSel = '0;
  logic       Stall = 1'b0;
  logic       Halt = 1'b0;
  logic [2:0] BrOp = '0;
  logic       Zero = 1'b0;
  logic [9:0] DestAddr = '0;
  logic [5:0] Offset = '0;
  logic [9:0] ProgCtr;
  logic       Busy, Done, Fault;

  prog_ctr_seq dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .ProgSel  (ProgSel),
    .Stall    (Stall),
    .Halt     (Halt),
    .BrOp     (BrOp),
    .Zero     (Zero),
    .DestAddr (DestAddr),
    .Offset   (Offset),
    .ProgCtr  (ProgCtr),
    .Busy     (Busy),
    .Done     (Done),
    .Fault    (Fault)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       start;
    logic [1:0] sel;
    logic       stall;
    logic       halt;
    logic [2:0] op;
    logic       zero;
    logic [9:0] dest;
    logic [5:0] off;
    logic [9:0] pc;
    logic       busy;
    logic       done;
    logic       fault;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic st, input logic [1:0] sel, input logic stall,
                              input logic halt, input logic [2:0] op, input logic z,
                              input logic [9:0] d, input logic [5:0] o, input logic [9:0] pc,
                              input logic b, input logic dn, input logic f);
    vec_t v;
    v.start = st; v.sel = sel; v.stall = stall; v.halt = halt; v.op = op; v.zero = z;
    v.dest = d; v.off = o; v.pc = pc; v.busy = b; v.done = dn; v.fault = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [9:0] pc, input logic b,
                       input logic dn, input logic f);
    n_vec++;
    if ({ProgCtr, Busy, Done, Fault} !== {pc, b, dn, f}) begin
      n_err++;
      $display("FAIL %s: got pc=%h busy=%b done=%b fault=%b, want pc=%h busy=%b done=%b fault=%b",
               name, ProgCtr, Busy, Done, Fault, pc, b, dn, f);
    end
  endtask

  task automatic drive(input vec_t v);
    Start = v.start; ProgSel = v.sel; Stall = v.stall; Halt = v.halt; BrOp = v.op;
    Zero = v.zero; DestAddr = v.dest; Offset = v.off;
  endtask

  task automatic apply(input vec_t v, input string name);
    vec_t e;
    @(negedge Clk);
    drive(v);
    exp_q.push_back(v);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty, got pc=%h want entry", name, ProgCtr);
    end else begin
      e = exp_q.pop_front();
      check(name, e.pc, e.busy, e.done, e.fault);
    end
  endtask

  initial begin
    //        st sel  stl hlt op    z  dest    off    | pc     b  d  f
    tbl.push_back(mk(1, 2'd1, 0, 0, NONE, 0, 10'h000, 6'h00, 10'h100, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, NONE, 0, 10'h000, 6'h00, 10'h101, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, NONE, 0, 10'h000, 6'h00, 10'h102, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, NONE, 0, 10'h000, 6'h00, 10'h103, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, JE,   1, 10'h050, 6'h00, 10'h050, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, JNE,  1, 10'h3AA, 6'h00, 10'h051, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, JNE,  0, 10'h001, 6'h00, 10'h001, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, REL,  0, 10'h000, 6'h3E, 10'h3FF, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, NONE, 0, 10'h000, 6'h00, 10'h000, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, JMP,  0, 10'h010, 6'h00, 10'h010, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, CALL, 0, 10'h200, 6'h00, 10'h200, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, RET,  0, 10'h000, 6'h00, 10'h011, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, REL,  0, 10'h000, 6'h05, 10'h016, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, REL,  0, 10'h000, 6'h1F, 10'h035, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, JE,   0, 10'h3FE, 6'h00, 10'h036, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, JMP,  0, 10'h3FE, 6'h00, 10'h3FE, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, REL,  0, 10'h000, 6'h03, 10'h001, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, 3'd7, 0, 10'h155, 6'h00, 10'h002, 1, 0, 0));
    tbl.push_back(mk(1, 2'd2, 0, 0, NONE, 0, 10'h000, 6'h00, 10'h003, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 1, 1, JMP,  0, 10'h123, 6'h00, 10'h003, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 1, JMP,  0, 10'h123, 6'h00, 10'h003, 0, 1, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, JMP,  0, 10'h155, 6'h00, 10'h003, 0, 1, 0));
    tbl.push_back(mk(1, 2'd3, 0, 0, NONE, 0, 10'h000, 6'h00, 10'h003, 0, 1, 0));
    tbl.push_back(mk(1, 2'd0, 0, 0, NONE, 0, 10'h000, 6'h00, 10'h000, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, CALL, 0, 10'h020, 6'h00, 10'h020, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, CALL, 0, 10'h030, 6'h00, 10'h030, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, CALL, 0, 10'h040, 6'h00, 10'h040, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, CALL, 0, 10'h050, 6'h00, 10'h050, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, CALL, 0, 10'h060, 6'h00, 10'h050, 0, 1, 1));
    tbl.push_back(mk(1, 2'd1, 0, 0, NONE, 0, 10'h000, 6'h00, 10'h100, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, RET,  0, 10'h000, 6'h00, 10'h100, 0, 1, 1));
    tbl.push_back(mk(1, 2'd2, 0, 0, NONE, 0, 10'h000, 6'h00, 10'h200, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, CALL, 0, 10'h300, 6'h00, 10'h300, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, CALL, 0, 10'h3F0, 6'h00, 10'h3F0, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 1, 0, RET,  0, 10'h000, 6'h00, 10'h3F0, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, RET,  0, 10'h000, 6'h00, 10'h301, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, RET,  0, 10'h000, 6'h00, 10'h201, 1, 0, 0));
    tbl.push_back(mk(0, 2'd0, 0, 0, NONE, 0, 10'h000, 6'h00, 10'h202, 1, 0, 0));

    repeat (2) @(posedge Clk);
    #1;
    check("reset_state", 10'h000, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    apply(mk(0, 2'd1, 0, 0, JMP, 0, 10'h155, 6'h00, 10'h000, 0, 0, 0), "idle_ignores_inputs");

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Async reset asserted and released between clock edges while running.
    @(negedge Clk);
    drive(mk(0, 2'd0, 1, 0, NONE, 0, 10'h000, 6'h00, 10'h000, 0, 0, 0));
    #1;
    Reset = 1'b0;
    #1;
    check("async_reset_mid_run", 10'h000, 1'b0, 1'b0, 1'b0);
    #1;
    Reset = 1'b1;
    Stall = 1'b0;
    apply(mk(1, 2'd3, 0, 0, NONE, 0, 10'h000, 6'h00, 10'h000, 0, 0, 0), "start_sel3_ignored");
    apply(mk(0, 2'd0, 0, 0, RET,  0, 10'h000, 6'h00, 10'h000, 0, 0, 0), "idle_ignores_ret");
    apply(mk(1, 2'd1, 0, 0, NONE, 0, 10'h000, 6'h00, 10'h100, 1, 0, 0), "restart_after_reset");
    apply(mk(0, 2'd0, 0, 0, RET,  0, 10'h000, 6'h00, 10'h100, 0, 1, 1), "ret_empty_after_reset");

    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
